// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order {pc, pc+4, inst} prefetch queue between IF2 and decode, 1-cycle push-to-pop, single-cycle flush.
// if2_ready_o drops while full (no write-through); define FETCH_BUF_BYPASS_EN for a combinational empty-queue bypass.
module fetch_buffer #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             if2_valid_i,
  output logic             if2_ready_o,
  input  logic [31:0]      if2_pc_i,
  input  logic [31:0]      if2_pc_plus_4_i,
  input  logic [31:0]      if2_inst_i,
  output logic             id_valid_o,
  input  logic             id_ready_i,
  output logic [31:0]      id_pc_o,
  output logic [31:0]      id_pc_plus_4_o,
  output logic [31:0]      id_inst_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [31:0]    NOP      = 32'h0000_0013;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] inst;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;
  entry_t w_in;
  entry_t w_out;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_in        = {if2_pc_i, if2_pc_plus_4_i, if2_inst_i};
  assign if2_ready_o = ~w_full;
  assign w_pop       = ~w_empty & id_ready_i & ~flush_i;

`ifdef FETCH_BUF_BYPASS_EN
  logic w_byp;
  logic w_byp_take;

  assign w_byp      = w_empty & ~flush_i;
  // A bypassed entry that decode accepts is never written into storage.
  assign w_byp_take = w_byp & if2_valid_i & id_ready_i;
  assign w_push     = if2_valid_i & ~w_full & ~flush_i & ~w_byp_take;

  always_comb begin
    id_valid_o = ~w_empty;
    w_out      = r_mem[r_head];
    if (w_byp) begin
      id_valid_o = if2_valid_i;
      w_out      = w_in;
    end
  end
`else
  assign w_push     = if2_valid_i & ~w_full & ~flush_i;
  assign id_valid_o = ~w_empty;
  assign w_out      = r_mem[r_head];
`endif

  // Storage contents behind an invalid head are undefined, so mask them.
  assign id_pc_o        = id_valid_o ? w_out.pc        : 32'h0;
  assign id_pc_plus_4_o = id_valid_o ? w_out.pc_plus_4 : 32'h0;
  assign id_inst_o      = id_valid_o ? w_out.inst      : NOP;
  assign count_o        = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_in;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed scoreboard bench for fetch_buffer (DEPTH=4); expectations follow FETCH_BUF_BYPASS_EN if defined.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_i;
  logic        if2_valid_i;
  logic        if2_ready_o;
  logic [31:0] if2_pc_i;
  logic [31:0] if2_pc_plus_4_i;
  logic [31:0] if2_inst_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus_4_o;
  logic [31:0] id_inst_o;
  logic [2:0]  count_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush_i         (flush_i),
    .if2_valid_i     (if2_valid_i),
    .if2_ready_o     (if2_ready_o),
    .if2_pc_i        (if2_pc_i),
    .if2_pc_plus_4_i (if2_pc_plus_4_i),
    .if2_inst_i      (if2_inst_i),
    .id_valid_o      (id_valid_o),
    .id_ready_i      (id_ready_i),
    .id_pc_o         (id_pc_o),
    .id_pc_plus_4_o  (id_pc_plus_4_o),
    .id_inst_o       (id_inst_o),
    .count_o         (count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle against the model, then advance the model.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    logic byp;
    logic ev;
    logic push_ok;
    logic pop_q;
    exp_t hd;
    if2_valid_i     = v;
    if2_pc_i        = pc;
    if2_pc_plus_4_i = pc + 32'd4;
    if2_inst_i      = inst;
    id_ready_i      = rdy;
    flush_i         = fl;
    @(negedge clk);
    byp = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
    byp = (sb.size() == 0) && !fl;
`endif
    ev = byp ? v : (sb.size() != 0);
    chk("if2_ready", 32'(if2_ready_o), 32'(sb.size() < DEPTH));
    chk("count", 32'(count_o), 32'(sb.size()));
    chk("id_valid", 32'(id_valid_o), 32'(ev));
    if (ev) begin
      if (byp) begin
        hd.pc   = pc;
        hd.inst = inst;
      end else begin
        hd = sb[0];
      end
      chk("id_pc", id_pc_o, hd.pc);
      chk("id_pc_plus_4", id_pc_plus_4_o, hd.pc + 32'd4);
      chk("id_inst", id_inst_o, hd.inst);
    end else begin
      chk("idle_pc", id_pc_o, 32'h0);
      chk("idle_pc_plus_4", id_pc_plus_4_o, 32'h0);
      chk("idle_inst", id_inst_o, NOP);
    end
    push_ok = v && (sb.size() < DEPTH) && !fl && !(byp && rdy);
    pop_q   = !byp && ev && rdy && !fl;
    if (fl) begin
      sb.delete();
    end else begin
      if (pop_q)   void'(sb.pop_front());
      if (push_ok) sb.push_back(exp_t'{pc, inst});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n     = 1'b0;
    flush_i     = 1'b0;
    if2_valid_i = 1'b0;
    if2_pc_i    = '0;
    if2_pc_plus_4_i = '0;
    if2_inst_i  = '0;
    id_ready_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_ready", 32'(if2_ready_o), 32'd1);
    chk("rst_inst", id_inst_o, NOP);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill to full, reject a fifth push, then reject again even with a concurrent pop
    for (int k = 0; k < 4; k++)
      cycle(1'b1, 32'h100 + 32'(4*k), 32'hA000_0000 + 32'(k), 1'b0, 1'b0);
    cycle(1'b1, 32'h110, 32'hA000_0004, 1'b0, 1'b0);
    cycle(1'b1, 32'h110, 32'hA000_0004, 1'b1, 1'b0);
    cycle(1'b1, 32'h110, 32'hA000_0004, 1'b1, 1'b0);
    repeat (5) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Continuous streaming, pointers wrap
    for (int k = 0; k < 10; k++)
      cycle(1'b1, 32'h200 + 32'(4*k), 32'hB000_0000 + 32'(k), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Simultaneous push and pop at count 2
    cycle(1'b1, 32'h400, 32'hC000_0000, 1'b0, 1'b0);
    cycle(1'b1, 32'h404, 32'hC000_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'h408, 32'hC000_0002, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with a concurrent push and pop
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 32'h500 + 32'(4*k), 32'hD000_0000 + 32'(k), 1'b0, 1'b0);
    cycle(1'b1, 32'h300, 32'hDEAD_0300, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Empty-queue entry: same-cycle with bypass, one cycle later without
    cycle(1'b1, 32'h600, 32'h0050_0093, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-operation
    cycle(1'b1, 32'h700, 32'hE000_0000, 1'b0, 1'b0);
    cycle(1'b1, 32'h704, 32'hE000_0001, 1'b0, 1'b0);
    if2_valid_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_valid", 32'(id_valid_o), 32'd0);
    chk("arst_ready", 32'(if2_ready_o), 32'd1);
    chk("arst_inst", id_inst_o, NOP);
    sb.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h800, 32'hF000_0000, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch queue between the IF2 fetch stage and the IF/ID pipeline register. It accepts {pc, pc+4, instruction} triples from IF2 through a valid/ready handshake. It presents them in order to the decode stage, so a decode stall no longer stalls the instruction-memory pipeline. A flush from branch/jump resolution in EX/MEM empties the queue in one cycle.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, 2..16
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- flush_i  input  1  discard all entries (redirect from EX/MEM)
- if2_valid_i  input  1  IF2 presents an entry
- if2_ready_o  output  1  buffer can accept; equals ~full
- if2_pc_i  input  32  current_pc of fetched instruction
- if2_pc_plus_4_i  input  32  pc_plus_4 of fetched instruction
- if2_inst_i  input  32  fetched instruction word
- id_valid_o  output  1  head entry valid for decode
- id_ready_i  input  1  decode consumes head this cycle
- id_pc_o  output  32  head current_pc
- id_pc_plus_4_o  output  32  head pc_plus_4
- id_inst_o  output  32  head instruction; 32'h0000_0013 (NOP) when id_valid_o=0
- count_o  output  PTR_W+1  number of stored entries, 0..DEPTH

## Operation
- Circular buffer: head pointer, tail pointer, and count register.
  - Push when if2_valid_i & if2_ready_o & ~flush_i; writes at tail; tail increments mod DEPTH.
  - Pop when id_valid_o & id_ready_i & ~flush_i; head increments mod DEPTH.
- Pointers wrap naturally from DEPTH-1 to 0.
- count: +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop.
- Full (count==DEPTH): if2_ready_o=0, even if a pop occurs in the same cycle. There is no write-through-on-full.
- Empty (count==0): id_valid_o=0 and data outputs are driven as pc=0, pc+4=0, inst=NOP. A pop request is ignored.
- flush_i has priority over everything:
  - at the next edge, head=tail=0 and count=0;
  - a push or pop presented in the flush cycle is discarded;
  - the pre-edge outputs are still driven during the flush cycle, but decode must ignore them.
- Order is strictly FIFO. Entries are never reordered or duplicated.
- Storage array is not reset. Only the pointers and count are reset.

## Timing
- Reset (async assert, sync release by the integrating block):
  - head=tail=0, count_o=0, id_valid_o=0, if2_ready_o=1;
  - id_pc_o=0, id_pc_plus_4_o=0, id_inst_o=NOP.
- Reset mid-operation discards all entries immediately. No partial push survives.
- Latency without the bypass configuration: an entry pushed at edge N is visible on id_* after edge N. The minimum push-to-pop time is 1 cycle.
- All outputs are functions of registered state only (head, count, storage), except in the bypass mode described below.
- Sustained throughput is 1 entry/cycle when not full. After full, one bubble occurs on the push side per pop cycle, because there is no write-through-on-full.

## Configuration
- FETCH_BUF_BYPASS_EN defined:
  - When count==0 and ~flush_i, id_valid_o = if2_valid_i and id_* = if2_* combinationally.
  - If id_ready_i is high in that cycle, the entry is consumed without being written. count and pointers are unchanged.
  - If id_ready_i is low, the entry is written normally.
- FETCH_BUF_BYPASS_EN undefined:
  - No combinational path from if2_* to id_*.
  - Empty-queue latency is 1 cycle as above.

## Test plan
- Reset with DEPTH=4: release reset, no traffic. Required: count_o=0, id_valid_o=0, if2_ready_o=1, id_inst_o=32'h0000_0013.
- Fill/drain: push pc=0x100,0x104,0x108,0x10C with id_ready_i=0. Then:
  - count_o=4 and if2_ready_o=0;
  - a fifth push of 0x110 is not accepted;
  - raising id_ready_i pops the entries in order 0x100..0x10C.
- Wrap-around: push/pop continuously for 10 entries pc=0x200+4k with id_ready_i=1. Required: the pop order matches exactly, count_o stays at most 1, and the pointers wrap past 3 without loss.
- Simultaneous push and pop at count=2: count_o stays 2. The head advances to the next entry and the new entry is appended at the tail.
- Flush: with 3 entries queued, assert flush_i together with a push of 0x300 and id_ready_i=1. Next cycle: count_o=0, id_valid_o=0, and 0x300 is never delivered.
- Bypass (FETCH_BUF_BYPASS_EN on): with the queue empty, push inst=0x00500093 with id_ready_i=1. Required: id_valid_o=1 and id_inst_o=0x00500093 in the same cycle, with count_o remaining 0. Without the macro, the entry appears one cycle later.
